isqrt_seq: RTL and testbench
============================

ISQRT_SEQ -- requirements
Module: isqrt_seq

Interface
REQ-001 Parameter: DW, default 8, radicand width; SHALL be even, legal range 4..16.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  request; sampled on rising clk, accepted only in IDLE.
REQ-005 Port: din  input  DW  unsigned radicand; sampled only on the accepting edge.
REQ-006 Port: busy  output  1  high in CALC and DONE states.
REQ-007 Port: done  output  1  one-cycle pulse; root/rem/exact valid and new.
REQ-008 Port: root  output  DW/2  floor(sqrt(din)).
REQ-009 Port: rem  output  DW/2+1  din - root*root; range 0..2*root.
REQ-010 Port: exact  output  1  high when rem == 0, i.e. din is a perfect square.

Function
REQ-011 FSM states IDLE, CALC, DONE; all outputs registered, no combinational input-to-output path.
REQ-012 IDLE: start=1 -> load din into shift register, clear partial root/remainder, cnt=DW/2-1, go CALC; start=0 -> stay.
REQ-013 CALC, one iteration per cycle: r = (r<<2) | next two MSBs of din; t = (q<<2)|1; if r >= t then r -= t, q = (q<<1)|1, else q <<= 1.
REQ-014 Internal partial remainder SHALL be DW/2+2 bits; no truncation of intermediate compare/subtract.
REQ-015 CALC with cnt==0 -> register root, rem, exact, assert done, go DONE; else cnt decrements.
REQ-016 Latency: done SHALL assert exactly DW/2 cycles after the accepting edge (4 cycles at DW=8).
REQ-017 DONE lasts exactly one cycle, then IDLE; done deasserts on that edge.
REQ-018 start in CALC or DONE SHALL be ignored, not queued; din changes there SHALL not affect the result.
REQ-019 root, rem, exact SHALL hold their last value until the next completion; not cleared by a new start.
REQ-020 Minimum issue interval: start accepted back-to-back every DW/2+2 cycles when held high.
REQ-021 Boundaries: din=0 -> root 0, rem 0, exact 1; din=2^DW-1 -> root 2^(DW/2)-1, rem 2*root.

Reset
REQ-022 rst_n low SHALL force IDLE, busy=0, done=0, root=0, rem=0, exact=0, cnt=0, regardless of clk.
REQ-023 Reset mid-CALC SHALL abort the operation without a done pulse; first start after release behaves as from power-up.

Structure
REQ-024 FSM state encodings and default DW SHALL live in the shared include/package sqrt_defs; no other constants shared.
REQ-025 Single iteration SHALL be a combinational sub-module isqrt_step (inputs r, q, two radicand bits; outputs next r, next q), instantiated once.
REQ-026 Target size 120-400 lines RTL including isqrt_step.

Verification
REQ-027 DW=8, din=225, start 1 cycle -> done after 4 cycles, root=15, rem=0, exact=1; din=255 -> root=15, rem=30, exact=0.
REQ-028 din=200 -> root=14, rem=4, exact=0; din=0 -> root=0, rem=0, exact=1; busy high exactly 5 cycles each op.
REQ-029 Exhaustive 0..255 -> root*root+rem==din and rem<=2*root; every r*r for r=0..15 returns root=r, exact=1.
REQ-030 start=1 with din=100 then, 2 cycles later, start=1 with din=9 -> single done, root=10; din=9 never processed.
REQ-031 Start din=196, drop rst_n during cycle 2 of CALC -> outputs 0 immediately, no done pulse; after release din=49 -> root=7.
REQ-032 start held high continuously with din=81 -> done pulse every 6 cycles, root=9 each time.

Source files
------------

// File: rtl/sqrt_defs.sv
// Shared definitions for the sequential integer square root: FSM state encodings
// and the default radicand width.
package sqrt_defs;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: bring down two radicand bits, trial-subtract (4q+1).
// Purely combinational; the caller registers r_nxt/q_nxt every cycle.
module isqrt_step #(
    parameter int DW = 8
) (
    input  logic [DW/2+1:0] r,
    input  logic [DW/2-1:0] q,
    input  logic [1:0]      bits,
    output logic [DW/2+1:0] r_nxt,
    output logic [DW/2-1:0] q_nxt
);

    localparam int HW = DW / 2;

    logic [HW+3:0] r_sh;
    logic [HW+1:0] t;
    logic          ge;

    // The compare uses the full shifted remainder so no carry is lost; the
    // subtraction result always fits back into HW+2 bits because it is <= 2q.
    always_comb begin
        r_sh  = {r, bits};
        t     = {q, 2'b01};
        ge    = (r_sh >= {2'b00, t});
        q_nxt = {q[HW-2:0], ge};
        r_nxt = ge ? (r_sh[HW+1:0] - t) : r_sh[HW+1:0];
    end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor(sqrt(din)) with remainder; done pulses DW/2 cycles after start is accepted.
// start is only accepted in IDLE; requests while busy are dropped, never queued.
module isqrt_seq
    import sqrt_defs::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW-1:0]   din,
    output logic            busy,
    output logic            done,
    output logic [DW/2-1:0] root,
    output logic [DW/2:0]   rem,
    output logic            exact
);

    localparam int HW = DW / 2;
    localparam int CW = (HW > 1) ? $clog2(HW) : 1;

    state_t          state;
    logic [DW-1:0]   sreg;
    logic [HW+1:0]   r;
    logic [HW-1:0]   q;
    logic [CW-1:0]   cnt;
    logic [HW+1:0]   r_nxt;
    logic [HW-1:0]   q_nxt;

    isqrt_step #(.DW(DW)) u_step (
        .r     (r),
        .q     (q),
        .bits  (sreg[DW-1:DW-2]),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sreg  <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            root  <= '0;
            rem   <= '0;
            exact <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg  <= din;
                        r     <= '0;
                        q     <= '0;
                        cnt   <= CW'(HW - 1);
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    sreg <= {sreg[DW-3:0], 2'b00};
                    r    <= r_nxt;
                    q    <= q_nxt;
                    // Results are captured straight from the final step so done
                    // lands on the same edge as the last iteration.
                    if (cnt == '0) begin
                        root  <= q_nxt;
                        rem   <= r_nxt[HW:0];
                        exact <= (r_nxt == '0);
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Scoreboard bench for isqrt_seq: driver pushes expected results, monitor checks on done.
module tb_isqrt_seq;

    localparam int DW = 8;
    localparam int HW = DW / 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [DW-1:0]   din   = '0;
    logic            busy;
    logic            done;
    logic [HW-1:0]   root;
    logic [HW:0]     rem;
    logic            exact;

    isqrt_seq #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .root  (root),
        .rem   (rem),
        .exact (exact)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int root;
        int rem;
        int exact;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    // Reference: largest r with r*r <= d, found by plain search.
    function automatic exp_t model(input int d);
        exp_t e;
        int   r = 0;
        while ((r + 1) * (r + 1) <= d) r++;
        e.d     = d;
        e.root  = r;
        e.rem   = d - r * r;
        e.exact = (e.rem == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t m_e;
    always @(posedge clk) begin
        #1;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual root=%0d required no done", root);
            end else begin
                m_e = sb.pop_front();
                chk($sformatf("root[din=%0d]", m_e.d), int'(root), m_e.root);
                chk($sformatf("rem[din=%0d]", m_e.d), int'(rem), m_e.rem);
                chk($sformatf("exact[din=%0d]", m_e.d), int'(exact), m_e.exact);
                chk($sformatf("identity[din=%0d]", m_e.d),
                    int'(root) * int'(root) + int'(rem), m_e.d);
            end
        end
    end

    task automatic do_op(input int d, input bit noise);
        int lat;
        int bc;
        int w;
        @(posedge clk); #1;
        w = 0;
        while (busy && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        start = 1'b1;
        din   = DW'(d);
        sb.push_back(model(d));
        @(posedge clk); #1;
        start = 1'b0;
        din   = DW'($urandom);
        lat   = -1;
        bc    = 0;
        for (int off = 0; off < 20; off++) begin
            if (busy) bc++;
            if (done && lat < 0) lat = off;
            if (!busy) break;
            if (noise && off >= 1 && off <= 4 && $urandom_range(1, 0) == 1) begin
                start = 1'b1;
                din   = DW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk($sformatf("latency[din=%0d]", d), lat, HW);
        chk($sformatf("busy_cycles[din=%0d]", d), bc, HW + 1);
    endtask

    initial begin
        int n0;
        int got;
        int cyc;
        int t_prev;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_root", int'(root), 0);
        chk("reset_rem", int'(rem), 0);
        chk("reset_exact", int'(exact), 0);
        rst_n = 1'b1;

        do_op(225, 1'b0);
        do_op(255, 1'b0);
        do_op(200, 1'b0);
        do_op(0, 1'b0);

        for (int d = 0; d < (1 << DW); d++) do_op(d, 1'b1);
        for (int i = 0; i < 100; i++) do_op(int'($urandom_range((1 << DW) - 1, 0)), 1'b1);

        // Second start while busy must be dropped.
        @(posedge clk); #1;
        start = 1'b1;
        din   = 8'd100;
        sb.push_back(model(100));
        n0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        din   = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("single_done_busy_start", done_cnt - n0, 1);

        // Reset in the middle of CALC aborts without a done pulse.
        start = 1'b1;
        din   = 8'd196;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n0    = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_root", int'(root), 0);
        chk("abort_rem", int'(rem), 0);
        chk("abort_exact", int'(exact), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_cnt - n0, 0);
        chk("root_after_abort", int'(root), 0);
        do_op(49, 1'b0);

        // start held high: back-to-back operations at the minimum interval.
        @(posedge clk); #1;
        start = 1'b1;
        din   = 8'd81;
        for (int i = 0; i < 3; i++) sb.push_back(model(81));
        got    = 0;
        cyc    = 0;
        t_prev = 0;
        while (got < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                if (got > 0) chk("issue_interval", cyc - t_prev, HW + 2);
                t_prev = cyc;
                got++;
            end
        end
        start = 1'b0;
        chk("held_start_dones", got, 3);

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
